// File: rtl/mmio_console_pkg.sv
// mmio_console_pkg: shared constants for the MMIO console block.
// Register offsets, STATUS bit positions, write-enable encodings and
// serializer state encodings used by mmio_console and its FIFO.
// Optional feature macro: MMIO_CONSOLE_PARITY_EN (adds the PARITY state).
package mmio_console_pkg;

    // Register byte offsets inside the 16-byte window
    localparam logic [3:0] OFS_TXDATA = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_TOHOST = 4'h8;

    // STATUS bit positions
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_BUSY    = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_PAR     = 4;
    localparam int ST_CNT_LSB = 8;

    // Write-enable encodings (one-hot access size)
    localparam logic [2:0] WE_NONE = 3'b000;
    localparam logic [2:0] WE_B    = 3'b001;
    localparam logic [2:0] WE_H    = 3'b010;
    localparam logic [2:0] WE_W    = 3'b100;

    // Serializer states
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef MMIO_CONSOLE_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;
`endif

    // Even parity bit: makes the total count of ones (data + parity) even
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/mmio_console_fifo.sv
// mmio_console_fifo: synchronous FIFO buffering console bytes.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears pointers/count)
//   i_push, i_data  write request and data
//   i_pop           read request; honoured only when non-empty
//   o_data          head entry (valid when !o_empty)
//   o_full/o_empty  occupancy flags
//   o_count         number of stored entries
// A push while full is accepted only if a pop happens in the same cycle.
module mmio_console_fifo
    import mmio_console_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];

    assign w_do_pop  = i_pop && !o_empty;
    // Pop frees a slot first, so a simultaneous push into a full FIFO fits
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is data only; it needs no reset
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/mmio_console.sv
// mmio_console: memory-mapped console and test-completion responder.
// Decodes a 16-byte window at MMIO_BASE on the core data port:
//   +0 TXDATA (push byte), +4 STATUS (W1C overflow), +8 TOHOST, +C reserved.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   addr, qin, we     core byte address, write data, one-hot write size
//   qout, hit_q       registered read data and window hit (1-cycle latency)
//   txd               UART serial output, idle high
//   test_done         sticky, set by a nonzero TOHOST write
//   test_result       last value written to TOHOST
// Optional feature macro: MMIO_CONSOLE_PARITY_EN adds an even-parity bit
// between the data bits and the stop bit and sets STATUS bit4.
module mmio_console
    import mmio_console_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter int                AWIDTH       = 14,
    parameter logic [AWIDTH-1:0] MMIO_BASE    = 14'h3FF0,
    parameter int                FIFO_DEPTH   = 8,
    parameter int                CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AWIDTH-1:0] addr,
    input  logic [XLEN-1:0]   qin,
    input  logic [2:0]        we,
    output logic [XLEN-1:0]   qout,
    output logic              hit_q,
    output logic              txd,
    output logic              test_done,
    output logic [XLEN-1:0]   test_result
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LOAD = BW'(CLKS_PER_BIT - 1);

    logic            w_hit;
    logic [3:0]      w_ofs;
    logic            w_wr;
    logic            w_push;
    logic            w_pop;
    logic [7:0]      w_fifo_data;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [3:0]      w_cnt_sat;
    logic [XLEN-1:0] w_status;
    logic [XLEN-1:0] w_rdata;
    logic            w_busy;
    logic            w_unused;

    logic [XLEN-1:0] r_qout;
    logic            r_hit;
    logic            r_ovf;
    logic            r_done;
    logic [XLEN-1:0] r_result;
    logic [2:0]      r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bitidx;
    logic [7:0]      r_shift;
`ifdef MMIO_CONSOLE_PARITY_EN
    logic            r_par;
`endif

    assign w_hit    = (addr[AWIDTH-1:4] == MMIO_BASE[AWIDTH-1:4]);
    assign w_ofs    = {addr[3:2], 2'b00};
    assign w_wr     = w_hit && |(we & (WE_B | WE_H | WE_W));
    assign w_push   = w_wr && (w_ofs == OFS_TXDATA);
    assign w_busy   = (r_state != S_IDLE);
    assign w_pop    = !w_busy && !w_empty;
    assign w_unused = ^addr[1:0];

    mmio_console_fifo #(
        .DATA_W (8),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (qin[7:0]),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        if (int'(w_count) > 15) w_cnt_sat = 4'hF;
        else                    w_cnt_sat = 4'(w_count);
    end

    always_comb begin
        w_status                      = '0;
        w_status[ST_FULL]             = w_full;
        w_status[ST_EMPTY]            = w_empty;
        w_status[ST_BUSY]             = w_busy;
        w_status[ST_OVF]              = r_ovf;
`ifdef MMIO_CONSOLE_PARITY_EN
        w_status[ST_PAR]              = 1'b1;
`endif
        w_status[ST_CNT_LSB +: 4]     = w_cnt_sat;
    end

    always_comb begin
        w_rdata = '0;
        case (w_ofs)
            OFS_STATUS: w_rdata = w_status;
            OFS_TOHOST: w_rdata = r_result;
            default:    w_rdata = '0;
        endcase
    end

    // Read response and register writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qout   <= '0;
            r_hit    <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_hit  <= w_hit;
            r_qout <= w_hit ? w_rdata : '0;
            // A push into a full FIFO is only dropped if no pop frees a slot
            if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            else if (w_wr && (w_ofs == OFS_STATUS) && qin[ST_OVF])
                r_ovf <= 1'b0;
            if (w_wr && (w_ofs == OFS_TOHOST)) begin
                r_result <= qin;
                if (qin != '0) r_done <= 1'b1;
            end
        end
    end

    // Serializer state machine
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitidx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state <= S_START;
                        r_baud  <= BAUD_LOAD;
                    end
                end
                S_START: begin
                    if (r_baud == '0) begin
                        r_state  <= S_DATA;
                        r_bitidx <= '0;
                        r_baud   <= BAUD_LOAD;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_baud == '0) begin
                        r_baud <= BAUD_LOAD;
                        if (r_bitidx == 3'd7) begin
`ifdef MMIO_CONSOLE_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bitidx <= r_bitidx + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`ifdef MMIO_CONSOLE_PARITY_EN
                S_PARITY: begin
                    if (r_baud == '0) begin
                        r_state <= S_STOP;
                        r_baud  <= BAUD_LOAD;
                    end else begin
                        r_baud <= r_baud - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_baud == '0) r_state <= S_IDLE;
                    else              r_baud  <= r_baud - 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Shift register holds data only; it is loaded on every pop
    always_ff @(posedge clk) begin
        if (w_pop)
            r_shift <= w_fifo_data;
        else if ((r_state == S_DATA) && (r_baud == '0))
            r_shift <= r_shift >> 1;
`ifdef MMIO_CONSOLE_PARITY_EN
        if (w_pop) r_par <= even_parity(w_fifo_data);
`endif
    end

    // txd decodes from reset state registers, so reset forces it high at once
    always_comb begin
        case (r_state)
            S_START:  txd = 1'b0;
            S_DATA:   txd = r_shift[0];
`ifdef MMIO_CONSOLE_PARITY_EN
            S_PARITY: txd = r_par;
`endif
            default:  txd = 1'b1;
        endcase
    end

    assign qout        = r_qout;
    assign hit_q       = r_hit;
    assign test_done   = r_done;
    assign test_result = r_result;

endmodule

// File: tb/tb_mmio_console.sv
// tb_mmio_console: scoreboard bench for mmio_console.
// Read responses and transmitted bytes are queued by the stimulus and
// checked by independent monitor processes.
module tb_mmio_console;

    localparam int          CPB  = 16;
    localparam logic [13:0] BASE = 14'h3FF0;
`ifdef MMIO_CONSOLE_PARITY_EN
    localparam logic [31:0] PB   = 32'h10;
    localparam int          NPAR = 1;
`else
    localparam logic [31:0] PB   = 32'h0;
    localparam int          NPAR = 0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] addr  = '0;
    logic [31:0] qin   = '0;
    logic [2:0]  we    = '0;
    logic [31:0] qout;
    logic        hit_q;
    logic        txd;
    logic        test_done;
    logic [31:0] test_result;

    int n_tests = 0;
    int n_fail  = 0;

    logic        tb_rd   = 1'b0;
    logic        rd_pend = 1'b0;
    logic [32:0] rd_q [$];
    logic [7:0]  tx_q [$];

    mmio_console #(
        .XLEN         (32),
        .AWIDTH       (14),
        .MMIO_BASE    (BASE),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addr        (addr),
        .qin         (qin),
        .we          (we),
        .qout        (qout),
        .hit_q       (hit_q),
        .txd         (txd),
        .test_done   (test_done),
        .test_result (test_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Read monitor: a read issued before one posedge is checked at the next negedge
    always @(negedge clk) begin : rd_mon
        logic [32:0] e;
        if (rd_pend) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got qout 0x%08h, expected no response", qout);
            end else begin
                e = rd_q.pop_front();
                check("rd_hit", 32'(hit_q), 32'(e[32]));
                check("rd_data", qout, e[31:0]);
            end
        end
        rd_pend = tb_rd;
    end

    task automatic wait_neg(input int n, inout logic ab);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (!rst_n) begin
                ab = 1'b1;
                return;
            end
        end
    endtask

    // UART receiver: samples the middle of each bit
    task automatic rx_frame();
        logic       ab;
        logic [7:0] b;
        logic [7:0] e;
        logic       sbit;
        logic       pbit;
        ab   = 1'b0;
        b    = '0;
        pbit = 1'b0;
        wait_neg(CPB / 2, ab);
        if (ab) return;
        check("start_bit", 32'(txd), 32'h0);
        for (int i = 0; i < 8; i++) begin
            wait_neg(CPB, ab);
            if (ab) return;
            b[i] = txd;
        end
        if (NPAR == 1) begin
            wait_neg(CPB, ab);
            if (ab) return;
            pbit = txd;
        end
        wait_neg(CPB, ab);
        if (ab) return;
        sbit = txd;
        if (tx_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL tx_unexpected: got byte 0x%02h, expected none", b);
        end else begin
            e = tx_q.pop_front();
            check("tx_byte", 32'(b), 32'(e));
            check("stop_bit", 32'(sbit), 32'h1);
            if (NPAR == 1) check("parity_bit", 32'(pbit), 32'(^e));
        end
    endtask

    always begin : tx_mon
        @(negedge clk);
        if (rst_n === 1'b1 && txd === 1'b0) rx_frame();
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [13:0] a, input logic [31:0] d, input logic [2:0] w);
        addr  = a;
        qin   = d;
        we    = w;
        tb_rd = 1'b0;
        @(posedge clk);
        #1;
        we = 3'b000;
    endtask

    task automatic bus_read(input logic [13:0] a, input logic eh, input logic [31:0] ed);
        rd_q.push_back({eh, ed});
        addr  = a;
        we    = 3'b000;
        tb_rd = 1'b1;
        @(posedge clk);
        #1;
        tb_rd = 1'b0;
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (txd === lvl && n < 1000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_fall();
        int n;
        n = 0;
        while (txd !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("frame_start_seen", 32'(txd), 32'h0);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (tx_q.size() != 0 && n < budget) begin
            idle(1);
            n++;
        end
        check("tx_drain", 32'(tx_q.size()), 32'h0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        int nl;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", 32'(txd), 32'h1);
        check("rst_qout", qout, 32'h0);
        check("rst_hit", 32'(hit_q), 32'h0);
        check("rst_done", 32'(test_done), 32'h0);
        check("rst_result", test_result, 32'h0);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_txd", 32'(txd), 32'h1);
        check("post_rst_qout", qout, 32'h0);
        bus_read(BASE + 14'h4, 1'b1, 32'h002 | PB);

        // Single byte 0x41: runs start0(16) 1(16) 0(80) 1(16) 0(16 + parity 0)
        tx_q.push_back(8'h41);
        bus_write(BASE, 32'h41, 3'b100);
        wait_fall();
        run_len(1'b0, n); check("run_start", 32'(n), 32'd16);
        run_len(1'b1, n); check("run_bit0", 32'(n), 32'd16);
        run_len(1'b0, n); check("run_bit1_5", 32'(n), 32'd80);
        run_len(1'b1, n); check("run_bit6", 32'(n), 32'd16);
        run_len(1'b0, n); check("run_bit7", 32'(n), 32'(16 + 16 * NPAR));
        idle(1);
        bus_read(BASE + 14'h4, 1'b1, 32'h006 | PB);
        idle(30);
        bus_read(BASE + 14'h4, 1'b1, 32'h002 | PB);

        // TOHOST
        bus_write(BASE + 14'h8, 32'h1, 3'b100);
        check("tohost_done", 32'(test_done), 32'h1);
        check("tohost_result", test_result, 32'h1);
        bus_read(BASE + 14'h8, 1'b1, 32'h1);
        bus_write(BASE + 14'h8, 32'h0, 3'b100);
        check("tohost_sticky", 32'(test_done), 32'h1);
        check("tohost_zero", test_result, 32'h0);
        bus_read(BASE + 14'h8, 1'b1, 32'h0);
        bus_write(BASE + 14'h8, 32'hDEADBEEF, 3'b100);
        bus_read(BASE + 14'h8, 1'b1, 32'hDEADBEEF);
        bus_read(BASE + 14'hC, 1'b1, 32'h0);
        bus_read(BASE, 1'b1, 32'h0);
        bus_read(BASE + 14'h6, 1'b1, 32'h002 | PB);

        // Decode miss
        bus_write(14'h0100, 32'h55, 3'b100);
        bus_write(14'h3FE8, 32'h12345678, 3'b100);
        bus_read(14'h0100, 1'b0, 32'h0);
        bus_read(14'h3FE8, 1'b0, 32'h0);
        bus_read(BASE + 14'h4, 1'b1, 32'h002 | PB);
        check("miss_result", test_result, 32'hDEADBEEF);

        // Overflow: byte 0x30 in flight, then 9 writes; the 9th is dropped
        tx_q.push_back(8'h30);
        bus_write(BASE, 32'h30, 3'b001);
        idle(3);
        for (int i = 0; i < 9; i++) begin
            if (i < 8) tx_q.push_back(8'h31 + 8'(i));
            bus_write(BASE, 32'h31 + 32'(i), (i % 2 == 1) ? 3'b010 : 3'b100);
        end
        bus_read(BASE + 14'h4, 1'b1, 32'h80D | PB);
        bus_write(BASE + 14'h4, 32'h7, 3'b100);
        bus_read(BASE + 14'h4, 1'b1, 32'h80D | PB);
        bus_write(BASE + 14'h4, 32'h8, 3'b100);
        bus_read(BASE + 14'h4, 1'b1, 32'h805 | PB);
        wait_drain(4000);
        idle(20);
        bus_read(BASE + 14'h4, 1'b1, 32'h002 | PB);

`ifdef MMIO_CONSOLE_PARITY_EN
        tx_q.push_back(8'h07);
        bus_write(BASE, 32'h07, 3'b001);
        wait_drain(400);
        idle(20);
`endif

        // Reset during data bit 3 of 0x52 (bit3 = 0), second byte queued
        bus_write(BASE, 32'h52, 3'b100);
        bus_write(BASE, 32'hA5, 3'b100);
        wait_fall();
        repeat (CPB * 4 + 8) @(negedge clk);
        check("pre_rst_bit3", 32'(txd), 32'h0);
        rst_n = 1'b0;
        #1;
        check("async_rst_txd", 32'(txd), 32'h1);
        repeat (3) @(posedge clk);
        #1;
        check("rst2_done", 32'(test_done), 32'h0);
        check("rst2_result", test_result, 32'h0);
        rst_n = 1'b1;
        idle(2);
        bus_read(BASE + 14'h4, 1'b1, 32'h002 | PB);
        nl = 0;
        repeat (400) begin
            @(negedge clk);
            if (txd !== 1'b1) nl++;
        end
        check("no_resume", 32'(nl), 32'h0);

        idle(2);
        check("rd_q_empty", 32'(rd_q.size()), 32'h0);
        check("tx_q_empty", 32'(tx_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
